fsqr: RTL and testbench



---
 rtl/fsqr.sv | 182 ++++++++++++++++++
 tb/tb_fsqr.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsqr.sv
// fsqr -- multi-cycle single-precision floating-point square unit (y = x*x).
//
// Accepts one IEEE-754 binary32 operand on a valid/ready handshake. It squares
// the 24-bit significand with an iterative shift-add multiplier, normalises and
// rounds the product to nearest-even, and returns the binary32 result on a
// second valid/ready handshake. Denormal results are flushed to zero and
// overflow saturates to +inf. The result sign is always 0.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rstn       in   1   asynchronous active-low reset
//   in_valid   in   1   operand x is valid
//   in_ready   out  1   unit can accept an operand (high only when idle)
//   x          in   32  operand {s, e[7:0], m[22:0]}
//   out_valid  out  1   y holds a completed result
//   out_ready  in   1   consumer accepts y
//   y          out  32  registered result
//
// Build option:
//   FSQR_RADIX4_EN  defined   -> radix-4 multiplier, 12 iterations (out_valid at cycle 14)
//                   undefined -> radix-2 multiplier, 24 iterations (out_valid at cycle 26)
//   Results are bit-identical in both builds.

module fsqr (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y
);

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

`ifdef FSQR_RADIX4_EN
    localparam logic [4:0] LAST_ITER = 5'd11;
    localparam int         STEP      = 2;
`else
    localparam logic [4:0] LAST_ITER = 5'd23;
    localparam int         STEP      = 1;
`endif

    state_t      state_q, state_d;
    logic [7:0]  exp_q, exp_d;
    logic [47:0] mcand_q, mcand_d;
    logic [23:0] mplier_q, mplier_d;
    logic [47:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] y_q, y_d;
    logic        out_valid_q, out_valid_d;
    logic        in_ready_q, in_ready_d;

    // Partial product for the current iteration.
    logic [47:0] addend;
    always_comb begin
`ifdef FSQR_RADIX4_EN
        case (mplier_q[1:0])
            2'd0:    addend = '0;
            2'd1:    addend = mcand_q;
            2'd2:    addend = mcand_q << 1;
            default: addend = mcand_q + (mcand_q << 1);
        endcase
`else
        addend = mplier_q[0] ? mcand_q : '0;
`endif
    end

    // Normalise / round the finished product. P lies in [2^46, 2^48), so the
    // leading one is either bit 47 (carry into the exponent) or bit 46.
    logic        hi;
    logic [22:0] frac_raw;
    logic        guard, sticky, round_up;
    logic [23:0] frac_sum;
    logic [9:0]  exp_sum;
    logic [31:0] norm_y;
    always_comb begin
        hi       = acc_q[47];
        frac_raw = hi ? acc_q[46:24] : acc_q[45:23];
        guard    = hi ? acc_q[23]    : acc_q[22];
        sticky   = hi ? (|acc_q[22:0]) : (|acc_q[21:0]);
        round_up = guard & (sticky | frac_raw[0]);
        // frac_sum[23] is the rounding carry; the low 23 bits are then zero.
        frac_sum = {1'b0, frac_raw} + {23'd0, round_up};
        exp_sum  = {1'b0, exp_q, 1'b0} - 10'd127 + {9'd0, hi} + {9'd0, frac_sum[23]};
        if ($signed(exp_sum) >= $signed(10'sd255)) begin
            norm_y = 32'h7F80_0000;
        end else if ($signed(exp_sum) <= $signed(10'sd0)) begin
            norm_y = 32'h0000_0000;
        end else begin
            norm_y = {1'b0, exp_sum[7:0], frac_sum[22:0]};
        end
    end

    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        y_d         = y_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    exp_d = x[30:23];
                    if (x[30:23] == 8'd0) begin
                        y_d         = 32'h0000_0000;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else if (x[30:23] == 8'hFF) begin
                        y_d         = (x[22:0] == 23'd0) ? 32'h7F80_0000 : 32'h7FC0_0000;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        mcand_d  = {24'd0, 1'b1, x[22:0]};
                        mplier_d = {1'b1, x[22:0]};
                        acc_d    = '0;
                        cnt_d    = 5'd0;
                        state_d  = MUL;
                    end
                end
            end
            MUL: begin
                acc_d    = acc_q + addend;
                mcand_d  = mcand_q << STEP;
                mplier_d = mplier_q >> STEP;
                if (cnt_q == LAST_ITER) begin
                    cnt_d   = 5'd0;
                    state_d = NORM;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            NORM: begin
                y_d         = norm_y;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Registered so that it is high exactly while the state is IDLE.
        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            exp_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y         = y_q;

endmodule

// File: tb/tb_fsqr.sv
// Testbench for fsqr: directed vectors, randomised operands with random
// output backpressure, a held-backpressure window, reset mid-multiply and a
// back-to-back throughput check. Expected results go into a scoreboard queue
// when an operand is accepted; a monitor pops and compares on each rising
// out_valid, checking both the value and the cycle it appeared.

module tb_fsqr;

`ifdef FSQR_RADIX4_EN
    localparam int LAT = 14;
`else
    localparam int LAT = 26;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;

    fsqr dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] yv;
        logic [31:0] due;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   bp_mode = 0;  // 0: out_ready high, 1: low, 2: random

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference: exact integer square of the significand, then generic
    // round-to-nearest-even to 24 significant bits.
    function automatic logic [31:0] ref_sq(input logic [31:0] xv);
        int unsigned       e;
        longint unsigned   sig, p, keep, rem, half;
        int                msb, sh, ex;
        logic [63:0]       kb;
        e = xv[30:23];
        if (e == 0) return 32'h0;
        if (e == 255) return (xv[22:0] == 0) ? 32'h7F800000 : 32'h7FC00000;
        sig = 64'(xv[22:0]) + (64'd1 << 23);
        p   = sig * sig;
        msb = 47;
        while (((p >> msb) & 64'd1) == 0) msb--;
        sh   = msb - 23;
        keep = p >> sh;
        rem  = p - (keep << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && keep[0])) keep++;
        ex = 2 * int'(e) - 127 + (msb - 46);
        if (keep == (64'd1 << 24)) begin
            keep = keep >> 1;
            ex++;
        end
        if (ex >= 255) return 32'h7F800000;
        if (ex <= 0) return 32'h0;
        kb = keep;
        return {1'b0, 8'(ex), kb[22:0]};
    endfunction

    // Output backpressure driver (sole writer of out_ready).
    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            #1;
            case (bp_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: compare at every rising out_valid, and check y holds while valid.
    initial begin
        logic        prev_v;
        logic [31:0] held;
        exp_t        e;
        prev_v = 1'b0;
        held   = '0;
        forever begin
            @(negedge clk);
            if (out_valid && !prev_v) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_out_valid: got y=%h with no pending operand (cycle %0d)", y, cyc);
                end else begin
                    e = q.pop_front();
                    chk("result", y, e.yv);
                    chk("latency", 32'(cyc), e.due);
                end
                held = y;
            end else if (out_valid && prev_v) begin
                chk("y_stable", y, held);
            end
            prev_v = out_valid;
        end
    end

    // Issue one operand; returns the accept cycle.
    task automatic send(input logic [31:0] xv, input logic [31:0] yexp, output int acc);
        int   t;
        exp_t e;
        @(negedge clk);
        #1;
        x        = xv;
        in_valid = 1'b1;
        t        = 0;
        while (!in_ready && t < 300) begin
            @(negedge clk);
            #1;
            t++;
        end
        acc = cyc;
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: in_ready stayed 0 for x=%h", xv);
        end else begin
            e.yv  = yexp;
            e.due = 32'(cyc + (((xv[30:23] == 8'd0) || (xv[30:23] == 8'hFF)) ? 1 : LAT));
            q.push_back(e);
        end
        @(negedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q.size() != 0 || out_valid) && t < 600) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0 || out_valid) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d results outstanding, out_valid=%b", q.size(), out_valid);
        end
    endtask

    logic [31:0] dir_x [8] = '{32'h40000000, 32'hC0400000, 32'h3FC00000, 32'h3F800001,
                               32'h5F800000, 32'h1F800000, 32'h00400000, 32'h7FC12345};
    logic [31:0] dir_y [8] = '{32'h40800000, 32'h41100000, 32'h40100000, 32'h3F800002,
                               32'h7F800000, 32'h00000000, 32'h00000000, 32'h7FC00000};

    initial begin
        int          a, a1, a2, a3, t;
        logic [31:0] rx, held;
        int unsigned sel, ev;

        rstn     = 1'b0;
        in_valid = 1'b0;
        x        = '0;
        repeat (3) @(negedge clk);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_y", y, 32'd0);
        #1;
        rstn = 1'b1;

        // Directed vectors.
        for (int i = 0; i < 8; i++) begin
            send(dir_x[i], dir_y[i], a);
            drain();
        end

        // Random operands with random output backpressure.
        bp_mode = 2;
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0:       ev = 0;
                1:       ev = 255;
                2:       ev = $urandom_range(55, 70);
                3:       ev = $urandom_range(185, 200);
                default: ev = $urandom_range(90, 165);
            endcase
            rx = {1'($urandom_range(0, 1)), 8'(ev), 23'($urandom)};
            if (sel == 1 && $urandom_range(0, 1) == 0) rx[22:0] = '0;
            send(rx, ref_sq(rx), a);
        end
        drain();
        bp_mode = 0;

        // Held backpressure with ignored input pulses.
        bp_mode = 1;
        repeat (3) @(negedge clk);
        send(32'h40000000, 32'h40800000, a);
        t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        held = y;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_y", y, 32'h40800000);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            in_valid = (i == 3 || i == 4);
            x        = 32'h3FC00000;
        end
        in_valid = 1'b0;
        bp_mode  = 0;
        t = 0;
        while (out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        drain();

        // Reset in the middle of the multiply.
        send(32'h3FC00000, 32'h40100000, a);
        while (cyc < a + 10) @(negedge clk);
        #1;
        rstn = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_y", y, 32'd0);
        q.delete();
        @(negedge clk);
        #1;
        rstn = 1'b1;
        send(32'h40000000, 32'h40800000, a);
        drain();

        // Back-to-back throughput with out_ready high.
        send(32'h40000000, 32'h40800000, a1);
        send(32'h3FC00000, 32'h40100000, a2);
        send(32'hC0400000, 32'h41100000, a3);
        chk("b2b_spacing_1", 32'(a2 - a1), 32'(LAT + 1));
        chk("b2b_spacing_2", 32'(a3 - a2), 32'(LAT + 1));
        drain();

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
